// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between the SPI command stream and a local master port.
// SPI commands are decoded on the rx_valid rising edge; RAM access is arbitrated round-robin.
module spi_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [9:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic              loc_rvalid,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              spi_ovf
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  state_t state_reg, state_next;

  logic              rx_valid_d;
  logic              capture;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              spi_pend, pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_wdata;
  logic              last_gnt_spi, cur_spi;

  logic              grant_spi;
  logic              mem_en_next, mem_we_next, loc_gnt_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              rd_done;

  assign capture = rx_valid && !rx_valid_d;
  assign cmd     = rx_data[9:8];
  assign rd_done = (state_reg == RD_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (spi_pend || loc_req) state_next = ACCESS;
      ACCESS:  state_next = mem_we ? IDLE : RD_WAIT;
      RD_WAIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // SPI wins unless the local port is also asking and SPI had the previous grant.
  always_comb begin
    grant_spi      = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    loc_gnt_next   = 1'b0;
    if (state_reg == IDLE && (spi_pend || loc_req)) begin
      grant_spi   = spi_pend && (!loc_req || !last_gnt_spi);
      mem_en_next = 1'b1;
      if (grant_spi) begin
        mem_we_next    = pend_we;
        mem_addr_next  = pend_addr;
        mem_wdata_next = pend_wdata;
      end else begin
        mem_we_next    = loc_we;
        mem_addr_next  = loc_addr;
        mem_wdata_next = loc_wdata;
        loc_gnt_next   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_d   <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      spi_pend     <= 1'b0;
      pend_we      <= 1'b0;
      pend_addr    <= '0;
      pend_wdata   <= '0;
      last_gnt_spi <= 1'b0;
      cur_spi      <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      loc_gnt      <= 1'b0;
      loc_rvalid   <= 1'b0;
      loc_rdata    <= '0;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      spi_ovf      <= 1'b0;
    end else begin
      rx_valid_d <= rx_valid;
      mem_en     <= mem_en_next;
      mem_we     <= mem_we_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      loc_gnt    <= loc_gnt_next;

      if (mem_en_next) begin
        cur_spi      <= grant_spi;
        last_gnt_spi <= grant_spi;
      end
      if (grant_spi) spi_pend <= 1'b0;

      if (capture) begin
        tx_valid <= 1'b0;
        case (cmd)
          2'b00: wr_addr <= rx_data[ADDR_W-1:0];
          2'b10: rd_addr <= rx_data[ADDR_W-1:0];
          default: begin
            // An op that is being granted this cycle is not overwritten, so no overflow.
            if (spi_pend && !grant_spi) spi_ovf <= 1'b1;
            spi_pend   <= 1'b1;
            pend_we    <= (cmd == 2'b01);
            pend_addr  <= (cmd == 2'b01) ? wr_addr : rd_addr;
            pend_wdata <= rx_data[DATA_W-1:0];
          end
        endcase
      end

      loc_rvalid <= rd_done && !cur_spi;
      if (rd_done && !cur_spi) loc_rdata <= mem_rdata;
      if (rd_done && cur_spi) begin
        tx_valid <= 1'b1;
        tx_data  <= mem_rdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a RAM model plus scoreboard queues of expected
// RAM accesses, local read data and SPI read data, checked by a negedge monitor.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       loc_req, loc_we;
  logic [7:0] loc_addr, loc_wdata;
  logic       loc_gnt, loc_rvalid;
  logic [7:0] loc_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata;
  logic       spi_ovf;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rvalid(loc_rvalid), .loc_rdata(loc_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .spi_ovf(spi_ovf)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_op_t;

  mem_op_t    exp_mem[$];
  logic [7:0] exp_loc[$];
  logic [7:0] exp_tx[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-port RAM model with registered read.
  logic [7:0] ram [256];
  initial begin
    mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  logic tx_prev = 1'b0;
  always @(negedge clk) begin
    mem_op_t e;
    logic [7:0] d;
    if (rst_n) begin
      if (mem_en) begin
        $display("mem access we=%0d addr=%02h wdata=%02h", mem_we, mem_addr, mem_wdata);
        n_checks++;
        assert (exp_mem.size() > 0) else begin
          n_fail++;
          $error("FAIL mem_unexpected: observed access addr %0h expected none", mem_addr);
        end
        if (exp_mem.size() > 0) begin
          e = exp_mem.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
      end else begin
        check("mem_we_idle", 32'(mem_we), 'h0);
      end
      if (loc_rvalid) begin
        $display("local read data=%02h", loc_rdata);
        n_checks++;
        assert (exp_loc.size() > 0) else begin
          n_fail++;
          $error("FAIL loc_rvalid_unexpected: observed data %0h expected none", loc_rdata);
        end
        if (exp_loc.size() > 0) begin
          d = exp_loc.pop_front();
          check("loc_rdata", 32'(loc_rdata), 32'(d));
        end
      end
      if (tx_valid && !tx_prev) begin
        $display("spi read data=%02h", tx_data);
        n_checks++;
        assert (exp_tx.size() > 0) else begin
          n_fail++;
          $error("FAIL tx_valid_unexpected: observed data %0h expected none", tx_data);
        end
        if (exp_tx.size() > 0) begin
          d = exp_tx.pop_front();
          check("tx_data", 32'(tx_data), 32'(d));
        end
      end
    end
    tx_prev <= tx_valid;
  end

  task automatic spi_word(input logic [9:0] w, input int hold);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = w;
    repeat (hold) @(posedge clk);
    #1 rx_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_valid"},   32'(tx_valid),   'h0);
    check({tag, "_tx_data"},    32'(tx_data),    'h0);
    check({tag, "_loc_gnt"},    32'(loc_gnt),    'h0);
    check({tag, "_loc_rvalid"}, 32'(loc_rvalid), 'h0);
    check({tag, "_loc_rdata"},  32'(loc_rdata),  'h0);
    check({tag, "_mem_en"},     32'(mem_en),     'h0);
    check({tag, "_mem_we"},     32'(mem_we),     'h0);
    check({tag, "_mem_addr"},   32'(mem_addr),   'h0);
    check({tag, "_mem_wdata"},  32'(mem_wdata),  'h0);
    check({tag, "_spi_ovf"},    32'(spi_ovf),    'h0);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1 rst_n = 1'b1;

    // SPI write 0xA5 to 0x12, rx_valid held 4 cycles on each word
    spi_word(10'h012, 4);
    exp_mem.push_back('{1'b1, 8'h12, 8'hA5});
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 10'h1A5;
    @(posedge clk); @(negedge clk); check("wr_mem_en_early", 32'(mem_en), 'h0);
    @(posedge clk); @(negedge clk); check("wr_mem_en", 32'(mem_en), 'h1);
    repeat (2) @(posedge clk);
    #1 rx_valid = 1'b0;
    repeat (4) @(posedge clk);

    // SPI read at 0x12
    spi_word(10'h212, 2);
    exp_mem.push_back('{1'b0, 8'h12, 8'h00});
    exp_tx.push_back(8'hA5);
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 10'h300;
    @(posedge clk); @(negedge clk); check("rd_tx_low", 32'(tx_valid), 'h0);
    @(posedge clk); @(negedge clk); check("rd_mem_en", 32'(mem_en), 'h1);
    @(posedge clk); @(negedge clk); check("rd_tx_early", 32'(tx_valid), 'h0);
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk);
    check("rd_tx_valid", 32'(tx_valid), 'h1);
    check("rd_tx_data", 32'(tx_data), 'hA5);
    repeat (5) @(posedge clk);
    @(negedge clk); check("rd_tx_hold", 32'(tx_valid), 'h1);
    spi_word(10'h200, 2);
    @(negedge clk); check("rd_tx_cleared", 32'(tx_valid), 'h0);

    // Local read at 0x12
    exp_mem.push_back('{1'b0, 8'h12, 8'h00});
    exp_loc.push_back(8'hA5);
    @(posedge clk); #1 loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h12;
    @(posedge clk); @(negedge clk); check("loc_gnt", 32'(loc_gnt), 'h1);
    @(posedge clk); #1 loc_req = 1'b0;
    @(negedge clk);
    check("loc_gnt_pulse", 32'(loc_gnt), 'h0);
    check("loc_rvalid_early", 32'(loc_rvalid), 'h0);
    @(posedge clk); @(negedge clk);
    check("loc_rvalid", 32'(loc_rvalid), 'h1);
    check("loc_rdata_direct", 32'(loc_rdata), 'hA5);
    repeat (3) @(posedge clk);

    // Arbitration from reset: SPI first, then alternating
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    spi_word(10'h010, 2);
    exp_mem.push_back('{1'b1, 8'h10, 8'h33});
    exp_mem.push_back('{1'b1, 8'h20, 8'h44});
    exp_mem.push_back('{1'b1, 8'h10, 8'h55});
    exp_mem.push_back('{1'b1, 8'h20, 8'h66});
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 10'h133;
    @(posedge clk); #1 loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h20; loc_wdata = 8'h44;
    @(posedge clk); #1 rx_valid = 1'b0;
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 10'h155;
    @(posedge clk); #1 loc_wdata = 8'h66;
    repeat (5) @(posedge clk);
    #1 loc_req = 1'b0; rx_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Two SPI writes captured while the local port occupies the RAM
    exp_mem.push_back('{1'b0, 8'h12, 8'h00});
    exp_loc.push_back(8'hA5);
    exp_mem.push_back('{1'b1, 8'h10, 8'hCC});
    @(posedge clk); #1 loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h12;
    rx_valid = 1'b1; rx_data = 10'h1BB;
    @(posedge clk); #1 rx_valid = 1'b0;
    @(negedge clk); check("ovf_before", 32'(spi_ovf), 'h0);
    @(posedge clk); #1 loc_req = 1'b0; rx_valid = 1'b1; rx_data = 10'h1CC;
    @(posedge clk); @(negedge clk); check("ovf_set", 32'(spi_ovf), 'h1);
    @(posedge clk); #1 rx_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); check("ovf_sticky", 32'(spi_ovf), 'h1);

    // Reset while a local read is in RD_WAIT
    exp_mem.push_back('{1'b0, 8'h12, 8'h00});
    @(posedge clk); #1 loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h12;
    @(posedge clk);
    @(posedge clk); #1 loc_req = 1'b0; rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("midrd");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("midrd_no_rvalid", 32'(loc_rvalid), 'h0);
    check("midrd_no_tx", 32'(tx_valid), 'h0);

    check("exp_mem_drained", 32'(exp_mem.size()), 'h0);
    check("exp_loc_drained", 32'(exp_loc.size()), 'h0);
    check("exp_tx_drained", 32'(exp_tx.size()), 'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
